mem_wb_stage: RTL
=================

# mem_wb_stage

MEM→WB pipeline register of the pipelined RV32I core, sitting directly upstream of the writeback result multiplexer. Each cycle it formats the raw data-memory word into a sign- or zero-extended load value (LB/LH/LW/LBU/LHU), registers it with the ALU result, PC+4, destination register and writeback control, and presents all of these as the W-stage signals. It also supports stall and flush, tracks instruction validity, and keeps a retired-instruction counter.

## Interface
- DATA_WIDTH, 32, datapath width; only 32 is supported.
- REG_ADDR_WIDTH, 5, register-file index width.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- EnW  in  1  register enable; 0 holds all W-stage state (stall).
- FlushW  in  1  synchronous bubble insert; overrides EnW.
- ValidM  in  1  the M-stage instruction is real, not a bubble.
- ALUResultM  in  DATA_WIDTH  ALU result, also the load address.
- ReadDataM  in  DATA_WIDTH  raw aligned word from data memory.
- PCPlus4M  in  DATA_WIDTH  PC+4 of the M-stage instruction.
- RdM  in  REG_ADDR_WIDTH  destination register.
- RegWriteM  in  1  register-file write request.
- ResultSrcM  in  2  writeback select: 00 ALU, 01 load, 10 PC+4.
- Funct3M  in  3  load type.
- ALUResultW, ReadDataW, PCPlus4W  out  DATA_WIDTH  registered W-stage values; ReadDataW is already extended.
- RdW  out  REG_ADDR_WIDTH; RegWriteW  out  1; ResultSrcW  out  2; ValidW  out  1.
- InstRetW  out  32  count of valid instructions that have entered W.
- MisalignW  out  1  misaligned-load flag; present only with MEM_MISALIGN_CHECK_EN.

## Operation
- Load formatting is combinational in M, using the byte offset off = ALUResultM[1:0]:
  - LB (000) / LBU (100): byte ReadDataM[8*off+7 : 8*off], sign- / zero-extended to 32 bits.
  - LH (001) / LHU (101): halfword selected by off[1], sign- / zero-extended.
  - LW (010): the full word.
  - Funct3 011/110/111: 0.
  - When ResultSrcM≠01, the formatted value is still computed and registered; the W-stage mux ignores it.
- Register update priority, evaluated at each edge:
  1. FlushW=1: ValidW←0, RegWriteW←0, data fields←0; counter unchanged.
  2. Else if EnW=1: all W fields ← M values; ValidW←ValidM; RegWriteW←RegWriteM & ValidM.
  3. Else: hold all state.
- RdW=0 with RegWriteW=1 passes through unchanged; x0 masking belongs to the register file.
- InstRetW increments by 1 on an edge where FlushW=0, EnW=1 and ValidM=1. It wraps 0xFFFFFFFF→0.

## Timing
- Latency is one cycle, M inputs to W outputs; there is no combinational path from input to output.
- Asynchronous reset: on rst_n low, every output (including InstRetW and MisalignW) goes to 0 immediately. The first capture is at the first rising edge after rst_n deasserts.
- Reset mid-stall or mid-flush discards the held contents; there is no replay.
- FlushW and EnW asserted together: flush wins.
- Stall of N cycles holds the outputs for N cycles and does not increment the counter.

## Configuration
- MEM_MISALIGN_CHECK_EN defined:
  - A load (ResultSrcM=01) is misaligned if LH/LHU has off[0]=1, or LW has off≠00.
  - On capture of a misaligned load: MisalignW←1, RegWriteW←0, ReadDataW←0.
  - The instruction is still counted.
  - MisalignW follows the same flush, stall and reset rules as the other W fields.
- Not defined: the MisalignW port is absent. Halfword select uses off[1] only; LW ignores off.

## Structure
- Shared package mem_wb_pkg holds:
  - load funct3 constants LB, LH, LW, LBU, LHU;
  - ResultSrc encodings RES_ALU=00, RES_LOAD=01, RES_PC4=10;
  - a packed struct for the W-stage bundle.
- Sub-module load_extend is purely combinational: ReadDataM, off, Funct3 → extended value, plus the misalign flag.
- The top level contains the register bank, the flush/enable priority logic and the counter.

## Test plan
- LB sign extension: ReadDataM=0x80FF7F01, ALUResultM=0x1003, Funct3=000, EnW=1 → next cycle ReadDataW=0xFFFFFF80, ValidW=1, InstRetW=1.
- LHU zero extension: same word, ALUResultM=0x1002, Funct3=101 → ReadDataW=0x000080FF. LH with the same inputs → 0xFFFF80FF.
- Stall then flush: capture Rd=5 with RegWrite=1, then EnW=0 for 3 cycles → outputs held and InstRetW unchanged. Then FlushW=1 with EnW=1 → ValidW=0, RegWriteW=0, counter unchanged.
- Reset mid-operation: pull rst_n low between edges while ValidW=1 and InstRetW=7 → all outputs 0 before the next edge.
- Counter wrap: preload InstRetW to 0xFFFFFFFF via 2^32−1 captures (or force), then one valid capture → InstRetW=0.
- Misaligned load, macro on: LW at ALUResultM=0x2002 with RegWriteM=1 → MisalignW=1, RegWriteW=0, ReadDataW=0. Macro off → ReadDataW=ReadDataM.

Source files
------------

// File: rtl/mem_wb_pkg.sv
// Shared types and encodings for the MEM->WB pipeline register.
// MEM_MISALIGN_CHECK_EN adds the misalign bit to the W-stage bundle.
package mem_wb_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  // Load funct3 encodings
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  // Writeback result select
  localparam logic [1:0] RES_ALU  = 2'b00;
  localparam logic [1:0] RES_LOAD = 2'b01;
  localparam logic [1:0] RES_PC4  = 2'b10;

  typedef struct packed {
    logic              valid;
    logic              reg_write;
`ifdef MEM_MISALIGN_CHECK_EN
    logic              misalign;
`endif
    logic [1:0]        result_src;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   alu_result;
    logic [XLEN-1:0]   read_data;
    logic [XLEN-1:0]   pc_plus4;
  } wb_bundle_t;

endpackage

// File: rtl/load_extend.sv
// Combinational load formatter: selects byte/halfword/word and extends it.
// MEM_MISALIGN_CHECK_EN adds the misalignment flag output.
module load_extend
  import mem_wb_pkg::*;
(
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      off,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] value_c
`ifdef MEM_MISALIGN_CHECK_EN
  ,
  output logic            misalign_c
`endif
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'(word >> {off, 3'b000});
    half_sel = off[1] ? word[31:16] : word[15:0];
    case (funct3)
      LB:      value_c = {{24{byte_sel[7]}}, byte_sel};
      LH:      value_c = {{16{half_sel[15]}}, half_sel};
      LW:      value_c = word;
      LBU:     value_c = {24'd0, byte_sel};
      LHU:     value_c = {16'd0, half_sel};
      default: value_c = '0;
    endcase
  end

`ifdef MEM_MISALIGN_CHECK_EN
  // Halfwords need even offsets, words need offset zero
  assign misalign_c = ((funct3 == LH || funct3 == LHU) && off[0])
                    || (funct3 == LW && off != 2'b00);
`endif

endmodule

// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline register with load formatting, stall/flush and retire counter.
// MEM_MISALIGN_CHECK_EN enables misaligned-load detection and the MisalignW port.
module mem_wb_stage
  import mem_wb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      EnW,
  input  logic                      FlushW,
  input  logic                      ValidM,
  input  logic [DATA_WIDTH-1:0]     ALUResultM,
  input  logic [DATA_WIDTH-1:0]     ReadDataM,
  input  logic [DATA_WIDTH-1:0]     PCPlus4M,
  input  logic [REG_ADDR_WIDTH-1:0] RdM,
  input  logic                      RegWriteM,
  input  logic [1:0]                ResultSrcM,
  input  logic [2:0]                Funct3M,
  output logic [DATA_WIDTH-1:0]     ALUResultW,
  output logic [DATA_WIDTH-1:0]     ReadDataW,
  output logic [DATA_WIDTH-1:0]     PCPlus4W,
  output logic [REG_ADDR_WIDTH-1:0] RdW,
  output logic                      RegWriteW,
  output logic [1:0]                ResultSrcW,
  output logic                      ValidW,
  output logic [31:0]               InstRetW
`ifdef MEM_MISALIGN_CHECK_EN
  ,
  output logic                      MisalignW
`endif
);

  wb_bundle_t      w_q, w_d, cap_c;
  logic [31:0]     cnt_q, cnt_d;
  logic [XLEN-1:0] load_value_c;
`ifdef MEM_MISALIGN_CHECK_EN
  logic            load_misalign_c;
`endif

  load_extend u_load_extend (
    .word       (ReadDataM),
    .off        (ALUResultM[1:0]),
    .funct3     (Funct3M),
    .value_c    (load_value_c)
`ifdef MEM_MISALIGN_CHECK_EN
    ,
    .misalign_c (load_misalign_c)
`endif
  );

  // Bundle as it would be captured from M this cycle
  always_comb begin
    cap_c            = '0;
    cap_c.valid      = ValidM;
    cap_c.reg_write  = RegWriteM & ValidM;
    cap_c.result_src = ResultSrcM;
    cap_c.rd         = RdM;
    cap_c.alu_result = ALUResultM;
    cap_c.read_data  = load_value_c;
    cap_c.pc_plus4   = PCPlus4M;
`ifdef MEM_MISALIGN_CHECK_EN
    if (ResultSrcM == RES_LOAD && load_misalign_c) begin
      cap_c.misalign  = 1'b1;
      cap_c.reg_write = 1'b0;
      cap_c.read_data = '0;
    end
`endif
  end

  // Flush beats enable; stall holds everything
  always_comb begin
    w_d   = w_q;
    cnt_d = cnt_q;
    if (FlushW) begin
      w_d = '0;
    end else if (EnW) begin
      w_d = cap_c;
      if (ValidM) cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q   <= '0;
      cnt_q <= '0;
    end else begin
      w_q   <= w_d;
      cnt_q <= cnt_d;
    end
  end

  assign ALUResultW = w_q.alu_result;
  assign ReadDataW  = w_q.read_data;
  assign PCPlus4W   = w_q.pc_plus4;
  assign RdW        = w_q.rd;
  assign RegWriteW  = w_q.reg_write;
  assign ResultSrcW = w_q.result_src;
  assign ValidW     = w_q.valid;
  assign InstRetW   = cnt_q;
`ifdef MEM_MISALIGN_CHECK_EN
  assign MisalignW  = w_q.misalign;
`endif

endmodule
